lockin_trace_buffer: RTL and testbench
======================================

# lockin_trace_buffer

Parametrised, multi-channel trace capture buffer between the lock-in CORDIC outputs and the VGA renderer. Each accepted sample set is scaled, clamped and decimated into one display column per channel. Completed sweeps are double-buffered and swapped only on a frame tick, which gives tear-free, freezable traces. The block runs entirely in the pixel clock domain; any upstream CDC is done before `i_valid`.

## Interface
- `DATA_WIDTH`, 42: width of each channel sample.
- `N_CH`, 2: number of channels, e.g. magnitude and phase.
- `CH_SIGNED`, 2'b10: per-channel bit; 1 means the channel is two's-complement.
- `COLS`, 320: columns per sweep.
- `Y_BITS`, 9: width of each stored trace code.
- `Y_MAX`, 460: maximum trace code; signed channels are centred on `Y_MAX/2`.
- `clk`  in  1: pixel clock; sole clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `i_valid`  in  1: sample strobe.
- `i_data`  in  N_CH*DATA_WIDTH: channel c occupies `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `i_shift`  in  N_CH*6: per-channel right shift.
- `i_mode`  in  2: 0 = first sample, 1 = peak (max), 2 = mean, 3 = reserved (treated as 0).
- `i_decim_log2`  in  4: 2^k samples per column; k ≤ 8, larger values are clamped to 8.
- `i_freeze`  in  1: blocks bank swaps.
- `i_frame_over`  in  1: one-cycle V-sync tick.
- `i_rd_en`  in  1: read request.
- `i_rd_col`  in  $clog2(COLS): column to read.
- `o_rd_data`  out  N_CH*Y_BITS: column codes from the front bank.
- `o_rd_valid`  out  1: qualifies `o_rd_data`.
- `o_bank_valid`  out  1: front bank holds a complete sweep.
- `o_sweep_done`  out  1: one-cycle pulse on each bank swap.

## Operation
- **Stage 1 (scale), per channel:**
  - Unsigned channel: logical shift right by `i_shift`, then clamp to [0, Y_MAX].
  - Signed channel: arithmetic shift, add `Y_MAX/2`, then clamp to [0, Y_MAX].
  - Intermediate width is DATA_WIDTH+1, so the offset add cannot overflow.
  - Result is registered.
- **Stage 2 (decimate), per channel:**
  - Accumulator width is Y_BITS+8; sample counter is 9 bits.
  - Mode and k are latched at the first sample of each column; changes mid-column take effect at the next column.
  - Column value: mode 0 = first sample; mode 1 = running max; mode 2 = (sum of 2^k samples) >> k, truncated.
  - The column is written to the back bank on its 2^k-th sample. Write data is the combinational final value including that sample.
- **Write pointer:** advances 0..COLS-1.
  - Writing column COLS-1 sets `pending` and returns the pointer to 0.
  - While `pending` is set, stage-2 input is discarded and accumulators are held cleared.
- **Swap:** on `i_frame_over` with `pending` set and `i_freeze` low:
  - Toggle the front bank.
  - Clear `pending`.
  - Set `o_bank_valid` (sticky until reset).
  - Pulse `o_sweep_done`.
- **Freeze:** holds the front bank indefinitely. A completed back bank waits in `pending`.
- **States:** CAPTURE (`pending` = 0) and HOLD (`pending` = 1). CAPTURE→HOLD on the last column write; HOLD→CAPTURE on a qualifying frame tick.
- **Read:** `o_rd_data` is the front bank at `i_rd_col`. If `i_rd_col` ≥ COLS, or `o_bank_valid` is 0, the output is 0.

## Timing
- Reset values: `o_rd_data` = 0, `o_rd_valid` = 0, `o_bank_valid` = 0, `o_sweep_done` = 0. Internally: front bank = 0, pointer = 0, counters and accumulators = 0, `pending` = 0. RAM contents are not reset.
- Sample-to-RAM latency: the sample presented with `i_valid` at cycle t is written at t+2. The pipeline is fully pipelined and accepts `i_valid` every cycle.
- Swap latency:
  - The swap takes effect on the cycle after the `i_frame_over` edge.
  - `o_sweep_done` is high in that same cycle.
  - If the last column write and `i_frame_over` coincide, there is no swap that cycle; the next tick swaps.
- Read latency: `o_rd_valid`/`o_rd_data` follow `i_rd_en`/`i_rd_col` by exactly 2 cycles (RAM read register plus output register). The bank select is sampled with the address.
- Reset deasserted mid-sweep: a partial column or sweep is lost and capture restarts at column 0.

## Structure
- Package `lockin_trace_pkg`: mode encodings (`MODE_SAMPLE`, `MODE_PEAK`, `MODE_MEAN`), `MAX_DECIM_LOG2` = 8, and a function for the accumulator width.
- Sub-module `lockin_trace_scaler`: shift, offset, clamp and register for one channel, instantiated N_CH times.
- Memory: a single inferred simple dual-port RAM of 2×COLS words (bank as address MSB), each word N_CH*Y_BITS wide, no read-during-write check.

## Test plan
- **Unsigned clamp:** N_CH = 2, mode 0, k = 0. Ch0 unsigned shift 0 with inputs 0, 460, 1000 → codes 0, 460, 460. Ch1 signed shift 0 with inputs −300, 0, +300 → codes 0, 230, 460.
- **Mean:** k = 2, inputs 10, 20, 30, 41 → code 25 written at t+2 after the 4th sample. Same inputs in mode 1 → 41.
- **Full sweep and swap:** fill 320 columns, then raise `i_frame_over`. Expect `o_sweep_done` for one cycle and `o_bank_valid` = 1. Reading column 319 returns its last written value with `o_rd_valid` 2 cycles after `i_rd_en`.
- **Hold:** after the sweep completes, feed 50 more samples with no frame tick → back bank unchanged. After the swap, capture resumes at column 0.
- **Freeze:** freeze = 1 over 3 frame ticks → no swap, front data stable. Freeze = 0 → swap on the next tick.
- **Boundaries:** `i_rd_col` = 400 → data 0. Last column write coincident with `i_frame_over` → swap deferred to the next tick. `rst_n` low mid-sweep → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/lockin_trace_pkg.sv
// Shared encodings and sizing helpers for the lock-in trace capture buffer.
package lockin_trace_pkg;

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_PEAK   = 2'd1,
    MODE_MEAN   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;

  localparam int unsigned MAX_DECIM_LOG2 = 8;
  localparam int unsigned CNT_W          = 9;

  // Room for 2^MAX_DECIM_LOG2 full-scale codes.
  function automatic int unsigned acc_width(input int unsigned y_bits);
    return y_bits + MAX_DECIM_LOG2;
  endfunction

endpackage

// File: rtl/lockin_trace_scaler.sv
// One channel of stage 1: shift, optional mid-scale offset, clamp to [0, Y_MAX], register.
module lockin_trace_scaler
  import lockin_trace_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 42,
  parameter int unsigned Y_BITS     = 9,
  parameter int unsigned Y_MAX      = 460,
  parameter bit          SIGNED     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [5:0]            i_shift,
  output logic [Y_BITS-1:0]     o_code
);

  localparam int unsigned IW = DATA_WIDTH + 1;
  localparam logic signed [IW-1:0] HALF_S = IW'(Y_MAX / 2);
  localparam logic signed [IW-1:0] MAX_S  = IW'(Y_MAX);

  logic signed [IW-1:0] ext_c;
  logic signed [IW-1:0] val_c;
  logic [Y_BITS-1:0]    code_d;
  logic [Y_BITS-1:0]    code_q;

  always_comb begin
    ext_c  = '0;
    val_c  = '0;
    code_d = '0;
    if (SIGNED) begin
      ext_c = $signed({i_data[DATA_WIDTH-1], i_data});
      val_c = (ext_c >>> i_shift) + HALF_S;
    end else begin
      ext_c = $signed({1'b0, i_data});
      val_c = $signed($unsigned(ext_c) >> i_shift);
    end
    if (val_c[IW-1]) begin
      code_d = '0;
    end else if (val_c > MAX_S) begin
      code_d = Y_BITS'(Y_MAX);
    end else begin
      code_d = val_c[Y_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) code_q <= '0;
    else        code_q <= code_d;
  end

  assign o_code = code_q;

endmodule

// File: rtl/lockin_trace_buffer.sv
// Multi-channel trace capture: scale, decimate into columns, double-buffer sweeps swapped on frame tick.
module lockin_trace_buffer
  import lockin_trace_pkg::*;
#(
  parameter int unsigned    DATA_WIDTH = 42,
  parameter int unsigned    N_CH       = 2,
  parameter logic [N_CH-1:0] CH_SIGNED = 2'b10,
  parameter int unsigned    COLS       = 320,
  parameter int unsigned    Y_BITS     = 9,
  parameter int unsigned    Y_MAX      = 460
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic [N_CH*DATA_WIDTH-1:0] i_data,
  input  logic [N_CH*6-1:0]          i_shift,
  input  logic [1:0]                 i_mode,
  input  logic [3:0]                 i_decim_log2,
  input  logic                       i_freeze,
  input  logic                       i_frame_over,
  input  logic                       i_rd_en,
  input  logic [$clog2(COLS)-1:0]    i_rd_col,
  output logic [N_CH*Y_BITS-1:0]     o_rd_data,
  output logic                       o_rd_valid,
  output logic                       o_bank_valid,
  output logic                       o_sweep_done
);

  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ACC_W  = acc_width(Y_BITS);
  localparam int unsigned WORD_W = N_CH * Y_BITS;

  logic [Y_BITS-1:0] s1_code [N_CH];
  logic              s1_valid_q, s1_valid_d;
  mode_e             s1_mode_q, s1_mode_d;
  logic [3:0]        s1_k_q, s1_k_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lockin_trace_scaler #(
      .DATA_WIDTH (DATA_WIDTH),
      .Y_BITS     (Y_BITS),
      .Y_MAX      (Y_MAX),
      .SIGNED     (CH_SIGNED[c])
    ) u_scaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .i_shift(i_shift[c*6 +: 6]),
      .o_code (s1_code[c])
    );
  end

  // Mode and decimation travel with the sample so they line up with the scaled code.
  always_comb begin
    s1_valid_d = i_valid;
    s1_mode_d  = (mode_e'(i_mode) == MODE_RSVD) ? MODE_SAMPLE : mode_e'(i_mode);
    s1_k_d     = (i_decim_log2 > 4'(MAX_DECIM_LOG2)) ? 4'(MAX_DECIM_LOG2) : i_decim_log2;
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mode_e              mode_q, mode_d;
  logic [3:0]         k_q, k_d;
  logic [ACC_W-1:0]   acc_q [N_CH];
  logic [ACC_W-1:0]   acc_d [N_CH];
  logic [ACC_W-1:0]   fin_c [N_CH];
  logic [COL_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               front_q, front_d;
  logic               bank_valid_q, bank_valid_d;
  logic               sweep_done_q, sweep_done_d;
  logic               first_c, last_c, we_c;
  mode_e              eff_mode_c;
  logic [3:0]         eff_k_c;
  logic [WORD_W-1:0]  wdata_c;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    k_d          = k_q;
    acc_d        = acc_q;
    wr_ptr_d     = wr_ptr_q;
    front_d      = front_q;
    bank_valid_d = bank_valid_q;
    sweep_done_d = 1'b0;
    we_c         = 1'b0;
    wdata_c      = '0;
    first_c      = (cnt_q == '0);
    eff_mode_c   = first_c ? s1_mode_q : mode_q;
    eff_k_c      = first_c ? s1_k_q : k_q;
    last_c       = (cnt_q == ((CNT_W'(1) << eff_k_c) - CNT_W'(1)));

    for (int unsigned c = 0; c < N_CH; c++) begin
      if (first_c) begin
        fin_c[c] = ACC_W'(s1_code[c]);
      end else begin
        case (eff_mode_c)
          MODE_PEAK: fin_c[c] = (ACC_W'(s1_code[c]) > acc_q[c]) ? ACC_W'(s1_code[c]) : acc_q[c];
          MODE_MEAN: fin_c[c] = acc_q[c] + ACC_W'(s1_code[c]);
          default:   fin_c[c] = acc_q[c];
        endcase
      end
      if (eff_mode_c == MODE_MEAN) wdata_c[c*Y_BITS +: Y_BITS] = Y_BITS'(fin_c[c] >> eff_k_c);
      else                         wdata_c[c*Y_BITS +: Y_BITS] = Y_BITS'(fin_c[c]);
    end

    case (state_q)
      ST_CAPTURE: begin
        if (s1_valid_q) begin
          if (first_c) begin
            mode_d = s1_mode_q;
            k_d    = s1_k_q;
          end
          if (last_c) begin
            we_c  = 1'b1;
            cnt_d = '0;
            for (int unsigned c = 0; c < N_CH; c++) acc_d[c] = '0;
            if (wr_ptr_q == COL_W'(COLS - 1)) begin
              wr_ptr_d = '0;
              state_d  = ST_HOLD;
            end else begin
              wr_ptr_d = wr_ptr_q + COL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = fin_c;
          end
        end
      end
      default: begin
        // Completed back bank waits here; incoming samples are dropped.
        cnt_d = '0;
        for (int unsigned c = 0; c < N_CH; c++) acc_d[c] = '0;
        if (i_frame_over && !i_freeze) begin
          front_d      = ~front_q;
          bank_valid_d = 1'b1;
          sweep_done_d = 1'b1;
          state_d      = ST_CAPTURE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_mode_q    <= MODE_SAMPLE;
      s1_k_q       <= '0;
      state_q      <= ST_CAPTURE;
      cnt_q        <= '0;
      mode_q       <= MODE_SAMPLE;
      k_q          <= '0;
      for (int unsigned c = 0; c < N_CH; c++) acc_q[c] <= '0;
      wr_ptr_q     <= '0;
      front_q      <= 1'b0;
      bank_valid_q <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_mode_q    <= s1_mode_d;
      s1_k_q       <= s1_k_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      k_q          <= k_d;
      acc_q        <= acc_d;
      wr_ptr_q     <= wr_ptr_d;
      front_q      <= front_d;
      bank_valid_q <= bank_valid_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  // Two banks of COLS words; the back bank is always the one not on display.
  logic [WORD_W-1:0] mem [2][COLS];
  logic [WORD_W-1:0] rd_word_q;
  logic              rd_col_ok_c;
  logic              rd_vld1_q, rd_vld1_d;
  logic              rd_ok1_q, rd_ok1_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  always_ff @(posedge clk) begin
    if (we_c) mem[~front_q][wr_ptr_q] <= wdata_c;
  end

  always_ff @(posedge clk) begin
    rd_word_q <= mem[front_q][rd_col_ok_c ? i_rd_col : '0];
  end

  always_comb begin
    rd_col_ok_c = (32'(i_rd_col) < COLS);
    rd_vld1_d   = i_rd_en;
    rd_ok1_d    = i_rd_en && rd_col_ok_c && bank_valid_q;
    rd_valid_d  = rd_vld1_q;
    rd_data_d   = rd_ok1_q ? rd_word_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld1_q  <= 1'b0;
      rd_ok1_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_vld1_q  <= rd_vld1_d;
      rd_ok1_q   <= rd_ok1_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_bank_valid = bank_valid_q;
  assign o_sweep_done = sweep_done_q;

endmodule

// File: tb/tb_lockin_trace_buffer.sv
// Directed bench for lockin_trace_buffer: scaling, decimation, sweep swap, hold, freeze, reset.
module tb_lockin_trace_buffer;

  localparam int unsigned DW   = 42;
  localparam int unsigned NCH  = 2;
  localparam int unsigned COLS = 320;
  localparam int unsigned YB   = 9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 i_valid;
  logic [NCH*DW-1:0]    i_data;
  logic [NCH*6-1:0]     i_shift;
  logic [1:0]           i_mode;
  logic [3:0]           i_decim_log2;
  logic                 i_freeze;
  logic                 i_frame_over;
  logic                 i_rd_en;
  logic [8:0]           i_rd_col;
  logic [NCH*YB-1:0]    o_rd_data;
  logic                 o_rd_valid;
  logic                 o_bank_valid;
  logic                 o_sweep_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lockin_trace_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .i_shift     (i_shift),
    .i_mode      (i_mode),
    .i_decim_log2(i_decim_log2),
    .i_freeze    (i_freeze),
    .i_frame_over(i_frame_over),
    .i_rd_en     (i_rd_en),
    .i_rd_col    (i_rd_col),
    .o_rd_data   (o_rd_data),
    .o_rd_valid  (o_rd_valid),
    .o_bank_valid(o_bank_valid),
    .o_sweep_done(o_sweep_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input longint d0, input longint d1, input int sh0 = 0, input int sh1 = 0);
    i_data  = {DW'(d1), DW'(d0)};
    i_shift = {6'(sh1), 6'(sh0)};
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_shift = '0;
  endtask

  task automatic fill(input int n, input longint d0, input longint d1);
    repeat (n) samp(d0, d1);
  endtask

  task automatic tick();
    i_frame_over = 1'b1;
    step();
    i_frame_over = 1'b0;
  endtask

  task automatic rd(input int col, input int e0, input int e1, input string tag);
    i_rd_en  = 1'b1;
    i_rd_col = 9'(col);
    step();
    i_rd_en = 1'b0;
    check_eq({tag, "_vld_early"}, 64'(o_rd_valid), 64'd0);
    step();
    check_eq({tag, "_vld"}, 64'(o_rd_valid), 64'd1);
    check_eq({tag, "_dat"}, 64'(o_rd_data), 64'({YB'(e1), YB'(e0)}));
  endtask

  initial begin
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_shift      = '0;
    i_mode       = 2'd0;
    i_decim_log2 = 4'd0;
    i_freeze     = 1'b0;
    i_frame_over = 1'b0;
    i_rd_en      = 1'b0;
    i_rd_col     = '0;
    repeat (3) step();
    check_eq("rst_rd_data", 64'(o_rd_data), 64'd0);
    check_eq("rst_rd_valid", 64'(o_rd_valid), 64'd0);
    check_eq("rst_bank_valid", 64'(o_bank_valid), 64'd0);
    check_eq("rst_sweep_done", 64'(o_sweep_done), 64'd0);
    rst_n = 1'b1;
    step();

    // Sweep A: clamp and shift cases in the first columns, ramp afterwards
    samp(0, -300);
    samp(460, 0);
    samp(1000, 300);
    samp(1000, -400, 2, 1);
    samp(64'(1) << 41, -1, 63, 5);
    for (int col = 5; col < 320; col++) samp(col, 0);
    repeat (3) step();
    check_eq("a_bank_valid_pre", 64'(o_bank_valid), 64'd0);
    tick();
    check_eq("a_sweep_done", 64'(o_sweep_done), 64'd1);
    check_eq("a_bank_valid", 64'(o_bank_valid), 64'd1);
    step();
    check_eq("a_sweep_done_pulse", 64'(o_sweep_done), 64'd0);
    rd(0, 0, 0, "a_col0");
    rd(1, 460, 230, "a_col1");
    rd(2, 460, 460, "a_col2");
    rd(3, 250, 30, "a_col3");
    rd(4, 0, 229, "a_col4");
    rd(319, 319, 230, "a_col319");
    rd(400, 0, 0, "a_col400");

    // Sweep B: mean then peak over 4 samples, then single-sample columns, then held extras
    i_mode       = 2'd2;
    i_decim_log2 = 4'd2;
    samp(10, 10); samp(20, 20); samp(30, 30); samp(41, 41);
    repeat (2) step();
    i_mode = 2'd1;
    samp(10, 10); samp(20, 20); samp(30, 30); samp(41, 41);
    repeat (2) step();
    i_mode       = 2'd0;
    i_decim_log2 = 4'd0;
    fill(317, 5, 0);
    samp(123, 0);
    fill(50, 7, 0);
    repeat (2) step();
    check_eq("b_hold_no_swap", 64'(o_sweep_done), 64'd0);
    rd(0, 0, 0, "b_front_still_a");
    tick();
    check_eq("b_sweep_done", 64'(o_sweep_done), 64'd1);
    step();
    rd(0, 25, 255, "b_mean");
    rd(1, 41, 271, "b_peak");
    rd(2, 5, 230, "b_col2");
    rd(319, 123, 230, "b_col319");

    // Sweep C: capture restarts at column 0, then freeze across three ticks
    samp(99, 0);
    fill(319, 100, 0);
    repeat (3) step();
    i_freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("c_frozen_no_swap", 64'(o_sweep_done), 64'd0);
      step();
    end
    rd(0, 25, 255, "c_frozen_front");
    i_freeze = 1'b0;
    tick();
    check_eq("c_unfreeze_swap", 64'(o_sweep_done), 64'd1);
    rd(0, 99, 230, "c_col0");
    rd(1, 100, 230, "c_col1");

    // Sweep D: frame tick coincides with the last column write
    fill(319, 200, 0);
    samp(201, 0);
    i_frame_over = 1'b1;
    step();
    i_frame_over = 1'b0;
    check_eq("d_coinc_no_swap", 64'(o_sweep_done), 64'd0);
    step();
    check_eq("d_coinc_no_swap2", 64'(o_sweep_done), 64'd0);
    tick();
    check_eq("d_next_tick_swap", 64'(o_sweep_done), 64'd1);
    rd(319, 201, 230, "d_col319");
    rd(0, 200, 230, "d_col0");

    // Reset mid-sweep with a read in flight
    i_rd_en  = 1'b1;
    i_rd_col = 9'd5;
    fill(100, 60, 0);
    check_eq("e_pre_rst_vld", 64'(o_rd_valid), 64'd1);
    check_eq("e_pre_rst_dat", 64'(o_rd_data), 64'({YB'(230), YB'(200)}));
    rst_n = 1'b0;
    step();
    check_eq("e_rst_rd_valid", 64'(o_rd_valid), 64'd0);
    check_eq("e_rst_rd_data", 64'(o_rd_data), 64'd0);
    check_eq("e_rst_bank_valid", 64'(o_bank_valid), 64'd0);
    check_eq("e_rst_sweep_done", 64'(o_sweep_done), 64'd0);
    i_rd_en = 1'b0;
    rst_n   = 1'b1;
    step();
    samp(77, 0);
    fill(319, 50, 0);
    repeat (3) step();
    tick();
    check_eq("e_sweep_done", 64'(o_sweep_done), 64'd1);
    check_eq("e_bank_valid", 64'(o_bank_valid), 64'd1);
    rd(0, 77, 230, "e_col0");
    rd(1, 50, 230, "e_col1");
    rd(400, 0, 0, "e_col400");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
